// File: rtl/vme_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vme_wr_arbiter
// Brief    : Round-robin owner of the single VME write channel, held from
//            command acceptance through data and ack for one requester.
// Revision : 1.0
// ============================================================================
module vme_wr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 8,
    parameter int DATA_W  = 64
) (
    input  logic                        clock,
    input  logic                        reset,

    input  logic [NUM_REQ-1:0]          io_req_cmd_valid,
    output logic [NUM_REQ-1:0]          io_req_cmd_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   io_req_cmd_bits_addr,
    input  logic [NUM_REQ*LEN_W-1:0]    io_req_cmd_bits_len,
    input  logic [NUM_REQ-1:0]          io_req_data_valid,
    output logic [NUM_REQ-1:0]          io_req_data_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   io_req_data_bits_data,
    output logic [NUM_REQ-1:0]          io_req_ack,

    output logic                        io_vme_wr_cmd_valid,
    input  logic                        io_vme_wr_cmd_ready,
    output logic [ADDR_W-1:0]           io_vme_wr_cmd_bits_addr,
    output logic [LEN_W-1:0]            io_vme_wr_cmd_bits_len,
    output logic                        io_vme_wr_data_valid,
    input  logic                        io_vme_wr_data_ready,
    output logic [DATA_W-1:0]           io_vme_wr_data_bits_data,
    input  logic                        io_vme_wr_ack,

    output logic [NUM_REQ-1:0]          io_grant,
    output logic                        io_busy,
    output logic                        io_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CMD      = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   last_q,  last_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic               err_q,   err_d;

    logic [NUM_REQ-1:0] w_pick;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_own_cmd_valid;
    logic [ADDR_W-1:0]  w_own_addr;
    logic [LEN_W-1:0]   w_own_len;
    logic               w_own_data_valid;
    logic [DATA_W-1:0]  w_own_data;
    logic               w_cmd_fire;
    logic               w_data_fire;

    // Round-robin pick: scanning k from far to near lets the nearest
    // valid requester after last_q overwrite any farther candidate.
    always_comb begin
        w_pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((j == ((int'(last_q) + k) % NUM_REQ)) && io_req_cmd_valid[j]) begin
                    w_pick    = '0;
                    w_pick[j] = 1'b1;
                end
            end
        end
    end

    // Owner-side mux driven by the one-hot grant; all-zero while idle.
    always_comb begin
        w_gidx           = '0;
        w_own_cmd_valid  = 1'b0;
        w_own_addr       = '0;
        w_own_len        = '0;
        w_own_data_valid = 1'b0;
        w_own_data       = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_q[j]) begin
                w_gidx           = IDX_W'(j);
                w_own_cmd_valid  = io_req_cmd_valid[j];
                w_own_addr       = io_req_cmd_bits_addr[j*ADDR_W +: ADDR_W];
                w_own_len        = io_req_cmd_bits_len[j*LEN_W +: LEN_W];
                w_own_data_valid = io_req_data_valid[j];
                w_own_data       = io_req_data_bits_data[j*DATA_W +: DATA_W];
            end
        end
    end

    assign w_cmd_fire  = (state_q == ST_CMD)  && w_own_cmd_valid  && io_vme_wr_cmd_ready;
    assign w_data_fire = (state_q == ST_DATA) && w_own_data_valid && io_vme_wr_data_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            beats_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beats_q <= beats_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beats_d = beats_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (|io_req_cmd_valid) begin
                    grant_d = w_pick;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_cmd_fire) begin
                    beats_d = w_own_len;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_data_fire) begin
                    if (beats_q == '0) begin
                        state_d = ST_WAIT_ACK;
                    end else begin
                        beats_d = beats_q - 1'b1;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (io_vme_wr_ack) begin
                    last_d  = w_gidx;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // An ack outside WAIT_ACK has no owner to go to; it is only recorded.
        if (io_vme_wr_ack && (state_q != ST_WAIT_ACK)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        io_vme_wr_cmd_valid      = (state_q == ST_CMD) && w_own_cmd_valid;
        io_vme_wr_cmd_bits_addr  = w_own_addr;
        io_vme_wr_cmd_bits_len   = w_own_len;
        io_req_cmd_ready         = ((state_q == ST_CMD) && io_vme_wr_cmd_ready) ? grant_q : '0;
        io_vme_wr_data_valid     = (state_q == ST_DATA) && w_own_data_valid;
        io_vme_wr_data_bits_data = w_own_data;
        io_req_data_ready        = ((state_q == ST_DATA) && io_vme_wr_data_ready) ? grant_q : '0;
        io_req_ack               = ((state_q == ST_WAIT_ACK) && io_vme_wr_ack) ? grant_q : '0;
        io_grant                 = grant_q;
        io_busy                  = (state_q != ST_IDLE);
        io_err                   = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_vme_wr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vme_wr_arbiter
// Brief    : Self-checking bench for vme_wr_arbiter: transaction table plus
//            hand-written reset, stray-ack and ack-collision sequences.
// Revision : 1.0
// ============================================================================
module tb_vme_wr_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int LW = 8;
    localparam int DW = 64;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_cmd_valid, req_cmd_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     req_data_valid, req_data_ready;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ack;
    logic              vme_cmd_valid, vme_cmd_ready;
    logic [AW-1:0]     vme_addr;
    logic [LW-1:0]     vme_len;
    logic              vme_data_valid, vme_data_ready;
    logic [DW-1:0]     vme_data;
    logic              vme_ack;
    logic [NR-1:0]     grant;
    logic              busy, err;
    logic [11:0]       w_outs;

    vme_wr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .io_req_cmd_valid         (req_cmd_valid),
        .io_req_cmd_ready         (req_cmd_ready),
        .io_req_cmd_bits_addr     (req_addr),
        .io_req_cmd_bits_len      (req_len),
        .io_req_data_valid        (req_data_valid),
        .io_req_data_ready        (req_data_ready),
        .io_req_data_bits_data    (req_data),
        .io_req_ack               (req_ack),
        .io_vme_wr_cmd_valid      (vme_cmd_valid),
        .io_vme_wr_cmd_ready      (vme_cmd_ready),
        .io_vme_wr_cmd_bits_addr  (vme_addr),
        .io_vme_wr_cmd_bits_len   (vme_len),
        .io_vme_wr_data_valid     (vme_data_valid),
        .io_vme_wr_data_ready     (vme_data_ready),
        .io_vme_wr_data_bits_data (vme_data),
        .io_vme_wr_ack            (vme_ack),
        .io_grant                 (grant),
        .io_busy                  (busy),
        .io_err                   (err)
    );

    assign w_outs = {req_cmd_ready, req_data_ready, req_ack, vme_cmd_valid,
                     vme_data_valid, grant, busy, err};

    always #5 clock = ~clock;

    typedef struct {
        int         j0;
        int         j1;
        int         len;
        logic [3:0] bp;
        int         dly;
        int         ntx;
        logic [5:0] order;
    } row_t;

    row_t  rows[6];
    string rname[6];

    int n_tests = 0;
    int n_fail  = 0;

    int jobs_left[NR], job_idx[NR], phase[NR], beat[NR], exp_job[NR], ack_cnt[NR];
    logic [DW-1:0] data_q[$];
    int txn_k, cur_owner, vme_left, ack_cd, ack_age, beats_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int r, input int j, input int b);
        return {8'(r), 8'(j), 40'h0, 8'(b)} ^ 64'hA5;
    endfunction

    function automatic logic [AW-1:0] job_addr(input int r, input int j);
        return 32'h1000 + 32'(r) * 32'h100 + 32'(j) * 32'h10;
    endfunction

    function automatic logic [NR-1:0] onehot(input int o);
        return NR'(1) << o;
    endfunction

    task automatic clear_inputs();
        req_cmd_valid  = '0;
        req_addr       = '0;
        req_len        = '0;
        req_data_valid = '0;
        req_data       = '0;
        vme_cmd_ready  = 1'b0;
        vme_data_ready = 1'b0;
        vme_ack        = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic drive_reqs(input logic [NR-1:0] cf, input logic [NR-1:0] df, input int len);
        for (int i = 0; i < NR; i++) begin
            if (phase[i] == 2 && df[i]) begin
                beat[i]++;
                if (beat[i] > len) begin
                    req_data_valid[i] = 1'b0;
                    phase[i] = 0;
                    job_idx[i]++;
                    jobs_left[i]--;
                end else begin
                    req_data[i*DW +: DW] = beat_data(i, job_idx[i], beat[i]);
                end
            end
            if (phase[i] == 1 && cf[i]) begin
                req_cmd_valid[i]     = 1'b0;
                phase[i]             = 2;
                beat[i]              = 0;
                req_data_valid[i]    = 1'b1;
                req_data[i*DW +: DW] = beat_data(i, job_idx[i], 0);
            end
            if (phase[i] == 0 && jobs_left[i] > 0) begin
                phase[i]             = 1;
                req_cmd_valid[i]     = 1'b1;
                req_addr[i*AW +: AW] = job_addr(i, job_idx[i]);
                req_len[i*LW +: LW]  = LW'(len);
            end
        end
    endtask

    // Requesters and VME slave are modelled here; expected beats are queued
    // when a command is accepted and popped as the VME side takes data.
    task automatic run_row(input row_t r, input int abort_beats, input logic exp_err, input string tag);
        logic [NR-1:0] cf, df;
        logic          last_fire, done, finished;
        int            owner;
        jobs_left[0] = r.j0;
        jobs_left[1] = r.j1;
        for (int i = 0; i < NR; i++) begin
            job_idx[i] = 0; phase[i] = 0; beat[i] = 0; exp_job[i] = 0; ack_cnt[i] = 0;
        end
        data_q.delete();
        txn_k = 0; cur_owner = 0; vme_left = 0; ack_cd = 0; ack_age = 0; beats_seen = 0;
        finished = 1'b0;
        vme_cmd_ready  = 1'b1;
        vme_data_ready = r.bp[0];
        drive_reqs('0, '0, r.len);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            cf = req_cmd_valid & req_cmd_ready;
            df = req_data_valid & req_data_ready;
            last_fire = 1'b0;
            if (ack_age == 1) begin
                check({tag, " idle bubble"}, {61'h0, busy, vme_cmd_valid, |req_cmd_ready}, 64'h0);
                ack_age = (req_cmd_valid != '0) ? 2 : 0;
            end else if (ack_age == 2) begin
                check({tag, " arb latency"}, {63'h0, vme_cmd_valid}, 64'h1);
                ack_age = 0;
            end
            if (vme_cmd_valid && vme_cmd_ready) begin
                if (txn_k >= r.ntx || txn_k >= 6) begin
                    check({tag, " extra txn"}, 64'(txn_k), 64'(r.ntx - 1));
                    owner = 0;
                end else begin
                    owner = r.order[txn_k] ? 1 : 0;
                end
                check({tag, " grant"}, 64'(grant), 64'(onehot(owner)));
                check({tag, " cmd addr"}, 64'(vme_addr), 64'(job_addr(owner, exp_job[owner])));
                check({tag, " cmd len"}, 64'(vme_len), 64'(r.len));
                for (int b = 0; b <= r.len; b++) data_q.push_back(beat_data(owner, exp_job[owner], b));
                exp_job[owner]++;
                cur_owner = owner;
                txn_k++;
                vme_left = r.len + 1;
            end
            if (vme_data_valid && vme_data_ready) begin
                if (data_q.size() == 0) check({tag, " extra beat"}, 64'(vme_data), 64'h0 - 1);
                else check({tag, " beat data"}, vme_data, data_q.pop_front());
                beats_seen++;
                if (vme_left > 0) begin
                    vme_left--;
                    if (vme_left == 0) last_fire = 1'b1;
                end
            end
            if (vme_ack) begin
                check({tag, " ack route"}, 64'(req_ack), 64'(onehot(cur_owner)));
                check({tag, " beats before ack"}, 64'(data_q.size()), 64'h0);
                ack_age = 1;
            end
            for (int i = 0; i < NR; i++) if (req_ack[i]) ack_cnt[i]++;
            @(posedge clock);
            #1;
            if (abort_beats > 0 && beats_seen >= abort_beats) begin
                reset = 1'b0;
                #1;
                check({tag, " outs in reset"}, 64'(w_outs), 64'h0);
                clear_inputs();
                return;
            end
            vme_ack = 1'b0;
            if (last_fire) ack_cd = r.dly;
            if (ack_cd > 0) begin
                ack_cd--;
                if (ack_cd == 0) vme_ack = 1'b1;
            end
            vme_data_ready = r.bp[2'((cyc + 1) % 4)];
            drive_reqs(cf, df, r.len);
            done = (jobs_left[0] == 0) && (jobs_left[1] == 0) && (phase[0] == 0) && (phase[1] == 0)
                   && (ack_cd == 0) && !vme_ack && !busy && (txn_k == r.ntx) && (ack_age == 0);
            if (done) begin
                finished = 1'b1;
                break;
            end
        end
        check({tag, " completed in budget"}, {63'h0, finished}, 64'h1);
        check({tag, " txn count"}, 64'(txn_k), 64'(r.ntx));
        check({tag, " acks req0"}, 64'(ack_cnt[0]), 64'(r.j0));
        check({tag, " acks req1"}, 64'(ack_cnt[1]), 64'(r.j1));
        check({tag, " beats total"}, 64'(beats_seen), 64'((r.j0 + r.j1) * (r.len + 1)));
        check({tag, " err flag"}, {63'h0, err}, {63'h0, exp_err});
        check({tag, " idle at end"}, {62'h0, busy, |grant}, 64'h0);
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            j0 j1 len  bp       dly ntx order (bit k = owner of txn k)
        rows[0] = '{1, 0, 0,   4'b1111, 2, 1, 6'b000000}; rname[0] = "single";
        rows[1] = '{1, 1, 3,   4'b1111, 1, 2, 6'b000010}; rname[1] = "simul";
        rows[2] = '{3, 3, 1,   4'b1111, 1, 6, 6'b101010}; rname[2] = "fair";
        rows[3] = '{1, 0, 7,   4'b1001, 1, 1, 6'b000000}; rname[3] = "backpr";
        rows[4] = '{0, 2, 2,   4'b0111, 3, 2, 6'b000011}; rname[4] = "req1only";
        rows[5] = '{1, 0, 255, 4'b1111, 1, 1, 6'b000000}; rname[5] = "len255";

        clear_inputs();
        reset = 1'b0;
        #1;
        check("reset outs", 64'(w_outs), 64'h0);
        req_cmd_valid  = '1;
        req_data_valid = '1;
        vme_cmd_ready  = 1'b1;
        vme_data_ready = 1'b1;
        vme_ack        = 1'b1;
        #20;
        check("reset outs driven", 64'(w_outs), 64'h0);

        for (int k = 0; k < 6; k++) begin
            do_reset();
            run_row(rows[k], 0, 1'b0, rname[k]);
        end

        // Reset after beat 2 of 4, then both request: req0 must win.
        do_reset();
        run_row(rows[1], 2, 1'b0, "abort");
        step();
        check("held reset outs", 64'(w_outs), 64'h0);
        reset = 1'b1;
        req_cmd_valid = 2'b11;
        req_addr      = {32'h2222_0000, 32'h1111_0000};
        step();
        check("post-reset grant", 64'(grant), 64'h1);
        check("post-reset cmd", {32'h0, 31'h0, vme_cmd_valid, vme_addr}, {32'h0, 31'h0, 1'b1, 32'h1111_0000});

        // Stray ack in IDLE: recorded, not forwarded, and arbitration still works.
        do_reset();
        vme_ack = 1'b1;
        #1;
        check("stray ack fwd", 64'(req_ack), 64'h0);
        step();
        vme_ack = 1'b0;
        check("stray ack err", {63'h0, err}, 64'h1);
        run_row(rows[0], 0, 1'b1, "post-stray");

        // Ack arriving on the last data beat is dropped; a later ack completes.
        do_reset();
        req_cmd_valid[0] = 1'b1;
        req_addr         = {32'h0, 32'h0000_3000};
        req_len          = '0;
        vme_cmd_ready    = 1'b1;
        step();
        check("collide cmd valid", {63'h0, vme_cmd_valid}, 64'h1);
        step();
        req_cmd_valid  = '0;
        req_data_valid = 2'b01;
        req_data       = {64'h0, 64'hDEAD_BEEF};
        vme_data_ready = 1'b1;
        vme_ack        = 1'b1;
        #1;
        check("collide ack fwd", 64'(req_ack), 64'h0);
        check("collide data", vme_data, 64'hDEAD_BEEF);
        step();
        req_data_valid = '0;
        check("collide err busy", {62'h0, err, busy}, 64'h3);
        check("late ack routed", 64'(req_ack), 64'h1);
        step();
        vme_ack = 1'b0;
        check("collide end", {62'h0, err, busy}, 64'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vme_wr_arbiter.md
# vme_wr_arbiter

Shares the single VME write channel (cmd / data / ack) between `NUM_REQ` tensor-store requesters, such as the output store and a second store engine. It grants one requester per write transaction, using round-robin order. It holds that grant from command acceptance through the last data beat until the write ack, then routes the ack back to the owner. It sits between the store engines and the VME write port.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..4)
- `ADDR_W`, 32: command address width
- `LEN_W`, 8: burst length field width; a transfer has len+1 beats
- `DATA_W`, 64: write data width

Ports (requester `i` occupies bit `i` or slice `i` of each vector):
- `clock`  in  1  single clock; all logic is rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `io_req_cmd_valid`  in  NUM_REQ  per-requester command valid
- `io_req_cmd_ready`  out  NUM_REQ  per-requester command ready
- `io_req_cmd_bits_addr`  in  NUM_REQ*ADDR_W  per-requester address
- `io_req_cmd_bits_len`  in  NUM_REQ*LEN_W  per-requester beat count minus 1
- `io_req_data_valid`  in  NUM_REQ  per-requester data valid
- `io_req_data_ready`  out  NUM_REQ  per-requester data ready
- `io_req_data_bits_data`  in  NUM_REQ*DATA_W  per-requester write data
- `io_req_ack`  out  NUM_REQ  per-requester write-complete pulse
- `io_vme_wr_cmd_valid` / `_ready` / `_bits_addr` / `_bits_len`  out/in/out/out  1/1/ADDR_W/LEN_W  VME command
- `io_vme_wr_data_valid` / `_ready` / `_bits_data`  out/in/out  1/1/DATA_W  VME write data
- `io_vme_wr_ack`  in  1  VME write complete
- `io_grant`  out  NUM_REQ  one-hot owner of the channel; all-zero when idle
- `io_busy`  out  1  high in any state other than IDLE
- `io_err`  out  1  sticky protocol-error flag

## Operation
- FSM states: IDLE, CMD, DATA, WAIT_ACK. Registered: `grant` (one-hot), `last` (index of the previous winner), `beats` (LEN_W bits), `err`.
- IDLE:
  - If any `io_req_cmd_valid` is high, pick the first valid requester scanning from `last+1` modulo NUM_REQ.
  - Register it into `grant` and go to CMD.
  - No ready is asserted in IDLE.
- CMD:
  - `io_vme_wr_cmd_*` carries the granted requester's cmd fields.
  - `io_req_cmd_ready[g]` = `io_vme_wr_cmd_ready`; all other readies are 0.
  - On fire: `beats` <= len, then go to DATA.
  - If the owner drops `cmd_valid`, stay in CMD; there is no timeout.
- DATA:
  - The granted data channel passes through in both directions; other `data_ready` = 0.
  - Each fire with `beats` != 0 decrements `beats`.
  - A fire with `beats` == 0 is the last beat; go to WAIT_ACK.
- WAIT_ACK:
  - On `io_vme_wr_ack`, `io_req_ack[g]` pulses in the same cycle (combinational).
  - `last` <= g, `grant` <= 0, go to IDLE.
- `io_vme_wr_ack` seen in IDLE, CMD or DATA: dropped (not forwarded), and sets `err`. `err` clears only on reset.
- Ungranted requesters see ready = 0 and ack = 0. Their valids are never consumed.
- `io_vme_wr_*_valid` is 0 outside CMD (cmd) and DATA (data). The bits are don't-care when valid is 0.

## Timing
- Reset (`reset` = 0), asynchronous: state = IDLE, `grant` = 0, `last` = NUM_REQ-1 (so requester 0 wins first), `beats` = 0, `err` = 0.
- Reset values of all outputs: every valid, ready and ack is 0; `io_grant` = 0; `io_busy` = 0; `io_err` = 0.
- Reset mid-transaction abandons the transfer immediately. No ack is generated.
- Arbitration latency: a `cmd_valid` seen in IDLE at cycle t gives `io_vme_wr_cmd_valid` = 1 at t+1.
- Minimum transaction: 1 (IDLE) + 1 (CMD) + (len+1) (DATA) + 1 (WAIT_ACK) cycles, with no backpressure and ack in the first WAIT_ACK cycle.
- There is one mandatory IDLE bubble between consecutive transactions.
- Handshakes are valid/ready: a transfer occurs when both are high at a rising edge. Pass-through paths are combinational, with no added beat latency.
- len = 255 gives 256 beats. `beats` never wraps below 0.
- Simultaneous last-beat fire and ack: the ack is not in WAIT_ACK, so it is dropped and sets `err`.

## Test plan
- Single requester: req0 sends a command with addr 0x1000, len 0, one beat 0xA5; ack 2 cycles later. Required: VME cmd at t+1, one data beat, `io_req_ack[0]` pulses once, `io_busy` returns to 0.
- Simultaneous start after reset: req0 and req1 both assert valid with len 3. Required: req0 is served first, 4 beats; then one IDLE cycle; then req1, 4 beats.
- Fairness: req0 and req1 assert continuously for 6 transactions. Required: grant order 0,1,0,1,0,1, and no beat from the non-owner reaches VME.
- Backpressure: `io_vme_wr_data_ready` is toggled 1,0,0,1 during len 7. Required: exactly 8 beats in order, WAIT_ACK entered only after beat 8.
- Reset mid-DATA: assert `reset` low after beat 2 of 4. Required: all outputs 0 immediately; after release, the next grant goes to req0.
- Stray ack: pulse `io_vme_wr_ack` in IDLE. Required: `io_err` = 1 and stays high, no `io_req_ack` pulse, arbitration otherwise unaffected.
